mem_request_arbiter: RTL
========================

MEM_REQUEST_ARBITER -- requirements
Module: mem_request_arbiter

Interface
REQ-001 Parameter ADDR_W, 16, address width.
REQ-002 Parameter DATA_W, 16, data width.
REQ-003 Parameter MAX_OUT, 4, max outstanding reads and, separately, max outstanding writes.
REQ-004 The block SHALL use one clock and a synchronous, active-high reset:
- clk  in  1  clock, all logic on posedge.
- reset  in  1  synchronous active-high reset.
REQ-005 The requester ports SHALL be as follows, with N=0,1 and one set per requester:
- reqN_valid  in  1  request present.
- reqN_we  in  1  1=write, 0=read.
- reqN_addr  in  ADDR_W  request address.
- reqN_wdata  in  DATA_W  write data.
- reqN_ready  out  1  request accepted this cycle.
- reqN_rvalid  out  1  one-cycle read-data pulse.
- reqN_rdata  out  DATA_W  read data, valid with rvalid.
REQ-006 The memory-controller ports SHALL be as follows:
- mc_wr_en / mc_wr_address / mc_wr_data  out  1/ADDR_W/DATA_W  write issue.
- mc_wr_ret_ack / mc_wr_ret_address  in  1/ADDR_W  write completion.
- mc_rd_en / mc_rd_address  out  1/ADDR_W  read issue.
- mc_rd_ret_ack / mc_rd_ret_address / mc_rd_ret_data  in  1/ADDR_W/DATA_W  read return.
- err_unmatched  out  1  sticky; set when a read return matches no table entry.

Function
REQ-007 A request SHALL complete its handshake in the cycle where reqN_valid and reqN_ready are both 1; at most one request is accepted per cycle across both requesters.
REQ-008 Arbitration SHALL be round-robin: when both requesters are eligible, grant goes to the requester not granted last; a lone eligible requester is always granted.
REQ-009 A read SHALL be eligible only when the read table holds fewer than MAX_OUT entries and no table entry holds the same address.
REQ-010 A write SHALL be eligible only when the write counter is below MAX_OUT and no read-table entry holds the same address.
REQ-011 reqN_ready SHALL be combinational: it is 1 only for the granted, eligible requester.
REQ-012 An accepted request SHALL drive mc_wr_en or mc_rd_en high for exactly one cycle, registered one cycle after the handshake, with its address and data. Both enables are never high in the same cycle.
REQ-013 An accepted read SHALL allocate a table entry holding {address, requester id}. The lowest free index is used.
REQ-014 On mc_rd_ret_ack, the returned address SHALL be matched to the table entry; one cycle later, reqN_rvalid pulses for that entry's requester with reqN_rdata equal to mc_rd_ret_data, and the entry is freed.
REQ-015 A read return with no matching entry SHALL be dropped and SHALL set err_unmatched, which stays set until reset.
REQ-016 The write counter SHALL increment on each accepted write and decrement on mc_wr_ret_ack; an increment and a decrement in the same cycle leave it unchanged. An ack arriving at count 0 is ignored.
REQ-017 A table entry freed in cycle T SHALL count as occupied for eligibility in cycle T; it becomes available in cycle T+1.
REQ-018 Table-full and address-conflict stalls SHALL hold reqN_ready at 0 without losing round-robin fairness; the pointer advances only on an accepted grant.

Reset
REQ-019 Reset SHALL set the following:
- all ready, rvalid, mc_*_en and err_unmatched outputs to 0;
- address and data outputs to 0;
- the read table empty and the write counter to 0;
- the round-robin pointer so that requester 0 wins the first tie.
REQ-020 Reset mid-operation SHALL discard all outstanding state. Read returns arriving after reset SHALL be treated per REQ-015.

Structure
REQ-021 Package mem_arb_pkg SHALL hold ADDR_W, DATA_W, MAX_OUT, the requester-id type and the read-table entry struct {valid, addr, id}.
REQ-022 The read table SHALL be a sub-module, rd_tag_table, with ports allocate, lookup/free, full and hit.

Verification
REQ-023 Single read: req0 reads 0x0096, the return arrives 3 cycles after mc_rd_en with data 0x1234 -> req0_rvalid pulses once with 0x1234 and the table is empty afterward.
REQ-024 Contention: req0 and req1 both assert valid continuously with reads to distinct addresses -> grants alternate 0,1,0,1, starting with 0 after reset.
REQ-025 Full table: four reads are outstanding and a fifth is requested -> ready stays 0 until a return arrives, then the fifth is accepted the cycle after the free.
REQ-026 Hazard: a read to 0x0010 is outstanding and a write to 0x0010 is requested -> the write stalls until the read returns; the write to 0x0011 proceeds.
REQ-027 An unmatched mc_rd_ret_ack with address 0x0FFF -> err_unmatched goes to 1 and stays 1, and no rvalid pulses.
REQ-028 Reset is asserted with 2 reads outstanding, then their returns arrive -> no rvalid pulses, err_unmatched is 1, and all counters are 0.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-requester memory request arbiter.
package mem_arb_pkg;

  localparam int ADDR_W  = 16;
  localparam int DATA_W  = 16;
  localparam int MAX_OUT = 4;
  localparam int NUM_REQ = 2;
  localparam int IDX_W   = $clog2(MAX_OUT);
  localparam int CNT_W   = $clog2(MAX_OUT + 1);

  // Requester identifier (0 or 1).
  typedef logic [0:0] req_id_t;

  // One outstanding-read slot.
  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] addr;
    req_id_t           id;
  } rd_entry_t;

  // Index of the lowest clear bit; only meaningful when at least one bit is clear.
  function automatic logic [IDX_W-1:0] lowest_free(input logic [MAX_OUT-1:0] valid_vec);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = MAX_OUT - 1; i >= 0; i--) begin
      if (!valid_vec[i]) begin
        idx = IDX_W'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/mem_request_arbiter_if.sv
// Requester and memory-controller signals of the arbiter.
// master: requesters plus memory controller; slave: the arbiter itself.
interface mem_request_arbiter_if;
  import mem_arb_pkg::*;

  logic              req0_valid;
  logic              req0_we;
  logic [ADDR_W-1:0] req0_addr;
  logic [DATA_W-1:0] req0_wdata;
  logic              req0_ready;
  logic              req0_rvalid;
  logic [DATA_W-1:0] req0_rdata;

  logic              req1_valid;
  logic              req1_we;
  logic [ADDR_W-1:0] req1_addr;
  logic [DATA_W-1:0] req1_wdata;
  logic              req1_ready;
  logic              req1_rvalid;
  logic [DATA_W-1:0] req1_rdata;

  logic              mc_wr_en;
  logic [ADDR_W-1:0] mc_wr_address;
  logic [DATA_W-1:0] mc_wr_data;
  logic              mc_wr_ret_ack;
  logic [ADDR_W-1:0] mc_wr_ret_address;

  logic              mc_rd_en;
  logic [ADDR_W-1:0] mc_rd_address;
  logic              mc_rd_ret_ack;
  logic [ADDR_W-1:0] mc_rd_ret_address;
  logic [DATA_W-1:0] mc_rd_ret_data;

  logic              err_unmatched;

  modport master (
    output req0_valid, req0_we, req0_addr, req0_wdata,
    input  req0_ready, req0_rvalid, req0_rdata,
    output req1_valid, req1_we, req1_addr, req1_wdata,
    input  req1_ready, req1_rvalid, req1_rdata,
    input  mc_wr_en, mc_wr_address, mc_wr_data,
    output mc_wr_ret_ack, mc_wr_ret_address,
    input  mc_rd_en, mc_rd_address,
    output mc_rd_ret_ack, mc_rd_ret_address, mc_rd_ret_data,
    input  err_unmatched
  );

  modport slave (
    input  req0_valid, req0_we, req0_addr, req0_wdata,
    output req0_ready, req0_rvalid, req0_rdata,
    input  req1_valid, req1_we, req1_addr, req1_wdata,
    output req1_ready, req1_rvalid, req1_rdata,
    output mc_wr_en, mc_wr_address, mc_wr_data,
    input  mc_wr_ret_ack, mc_wr_ret_address,
    output mc_rd_en, mc_rd_address,
    input  mc_rd_ret_ack, mc_rd_ret_address, mc_rd_ret_data,
    output err_unmatched
  );

endinterface

// File: rtl/mem_request_arbiter_rd_tag_table.sv
// Outstanding-read table: allocates the lowest free slot, answers address
// lookups for both requesters, and matches/frees entries on read return.
// A slot freed this cycle still reads as occupied until the next cycle.
module rd_tag_table
  import mem_arb_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              i_alloc,
  input  logic [ADDR_W-1:0] i_alloc_addr,
  input  req_id_t           i_alloc_id,
  input  logic [ADDR_W-1:0] i_lookup0_addr,
  input  logic [ADDR_W-1:0] i_lookup1_addr,
  output logic              o_hit0,
  output logic              o_hit1,
  input  logic              i_free,
  input  logic [ADDR_W-1:0] i_free_addr,
  output logic              o_free_hit,
  output req_id_t           o_free_id,
  output logic              o_full
);

  rd_entry_t          r_tab [MAX_OUT];
  logic [MAX_OUT-1:0] w_valid_vec;
  logic               w_hit0;
  logic               w_hit1;
  logic               w_free_hit;
  logic [IDX_W-1:0]   w_free_idx;
  req_id_t            w_free_id;
  logic [IDX_W-1:0]   w_alloc_idx;

  // Address compare of every valid slot against both lookups and the return address.
  always_comb begin
    w_valid_vec = '0;
    w_hit0      = 1'b0;
    w_hit1      = 1'b0;
    w_free_hit  = 1'b0;
    w_free_idx  = '0;
    w_free_id   = 1'b0;
    for (int i = 0; i < MAX_OUT; i++) begin
      w_valid_vec[i] = r_tab[i].valid;
      if (r_tab[i].valid && (r_tab[i].addr == i_lookup0_addr)) begin
        w_hit0 = 1'b1;
      end else begin
        w_hit0 = w_hit0;
      end
      if (r_tab[i].valid && (r_tab[i].addr == i_lookup1_addr)) begin
        w_hit1 = 1'b1;
      end else begin
        w_hit1 = w_hit1;
      end
      // Addresses are unique in the table, so at most one slot matches.
      if (r_tab[i].valid && (r_tab[i].addr == i_free_addr)) begin
        w_free_hit = 1'b1;
        w_free_idx = IDX_W'(i);
        w_free_id  = r_tab[i].id;
      end else begin
        w_free_hit = w_free_hit;
      end
    end
  end

  assign w_alloc_idx = lowest_free(w_valid_vec);
  assign o_full      = &w_valid_vec;
  assign o_hit0      = w_hit0;
  assign o_hit1      = w_hit1;
  assign o_free_hit  = w_free_hit;
  assign o_free_id   = w_free_id;

  // Slot state: clear on matched return, fill lowest free slot on accepted read.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < MAX_OUT; i++) begin
        r_tab[i] <= '0;
      end
    end else begin
      if (i_free && w_free_hit) begin
        r_tab[w_free_idx].valid <= 1'b0;
      end
      // The freed slot is still valid here, so it can never equal w_alloc_idx.
      if (i_alloc && !o_full) begin
        r_tab[w_alloc_idx] <= '{valid: 1'b1, addr: i_alloc_addr, id: i_alloc_id};
      end
    end
  end

endmodule

// File: rtl/mem_request_arbiter.sv
// Two-requester round-robin arbiter in front of a memory controller.
// Tracks outstanding reads in a tag table (for return routing and
// read-after-read / write-after-read hazards) and outstanding writes in a counter.
module mem_request_arbiter
  import mem_arb_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  mem_request_arbiter_if.slave  bus
);

  logic [NUM_REQ-1:0] w_valid;
  logic [NUM_REQ-1:0] w_we;
  logic [NUM_REQ-1:0] w_hit;
  logic [NUM_REQ-1:0] w_elig;
  logic [ADDR_W-1:0]  w_addr  [NUM_REQ];
  logic [DATA_W-1:0]  w_wdata [NUM_REQ];

  logic               w_tab_full;
  logic               w_hit0;
  logic               w_hit1;
  logic               w_ret_hit;
  req_id_t            w_ret_id;

  req_id_t            w_gnt;
  logic               w_accept;
  logic               w_acc_we;
  logic [ADDR_W-1:0]  w_acc_addr;
  logic [DATA_W-1:0]  w_acc_wdata;
  logic               w_rd_alloc;
  logic               w_wr_inc;
  logic               w_wr_dec;

  req_id_t            r_last;
  logic [CNT_W-1:0]   r_wr_cnt;
  logic               r_wr_en;
  logic [ADDR_W-1:0]  r_wr_addr;
  logic [DATA_W-1:0]  r_wr_data;
  logic               r_rd_en;
  logic [ADDR_W-1:0]  r_rd_addr;
  logic [NUM_REQ-1:0] r_rvalid;
  logic [DATA_W-1:0]  r_rdata0;
  logic [DATA_W-1:0]  r_rdata1;
  logic               r_err;

  assign w_valid    = {bus.req1_valid, bus.req0_valid};
  assign w_we       = {bus.req1_we, bus.req0_we};
  assign w_addr[0]  = bus.req0_addr;
  assign w_addr[1]  = bus.req1_addr;
  assign w_wdata[0] = bus.req0_wdata;
  assign w_wdata[1] = bus.req1_wdata;
  assign w_hit      = {w_hit1, w_hit0};

  rd_tag_table u_rd_tag_table (
    .clk            (clk),
    .reset          (reset),
    .i_alloc        (w_rd_alloc),
    .i_alloc_addr   (w_acc_addr),
    .i_alloc_id     (w_gnt),
    .i_lookup0_addr (bus.req0_addr),
    .i_lookup1_addr (bus.req1_addr),
    .o_hit0         (w_hit0),
    .o_hit1         (w_hit1),
    .i_free         (bus.mc_rd_ret_ack),
    .i_free_addr    (bus.mc_rd_ret_address),
    .o_free_hit     (w_ret_hit),
    .o_free_id      (w_ret_id),
    .o_full         (w_tab_full)
  );

  // Per-requester eligibility: capacity available and no outstanding read to the same address.
  always_comb begin
    w_elig = '0;
    for (int n = 0; n < NUM_REQ; n++) begin
      if (reset || !w_valid[n]) begin
        w_elig[n] = 1'b0;
      end else if (w_we[n]) begin
        w_elig[n] = (r_wr_cnt < CNT_W'(MAX_OUT)) && !w_hit[n];
      end else begin
        w_elig[n] = !w_tab_full && !w_hit[n];
      end
    end
  end

  // Round-robin pick: on a tie the requester not granted last wins.
  always_comb begin
    w_gnt = 1'b0;
    case (w_elig)
      2'b01:   w_gnt = 1'b0;
      2'b10:   w_gnt = 1'b1;
      2'b11:   w_gnt = ~r_last;
      default: w_gnt = 1'b0;
    endcase
  end

  assign w_accept    = |w_elig;
  assign w_acc_we    = w_we[w_gnt];
  assign w_acc_addr  = w_addr[w_gnt];
  assign w_acc_wdata = w_wdata[w_gnt];
  assign w_rd_alloc  = w_accept && !w_acc_we;
  assign w_wr_inc    = w_accept && w_acc_we;
  assign w_wr_dec    = bus.mc_wr_ret_ack && (r_wr_cnt != '0);

  assign bus.req0_ready = w_accept && (w_gnt == 1'b0);
  assign bus.req1_ready = w_accept && (w_gnt == 1'b1);

  // Issue accepted request to the controller one cycle later; pointer moves only on a grant.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_last    <= 1'b1;
      r_wr_en   <= 1'b0;
      r_rd_en   <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
      r_rd_addr <= '0;
    end else begin
      r_wr_en <= w_accept && w_acc_we;
      r_rd_en <= w_accept && !w_acc_we;
      if (w_accept) begin
        r_last <= w_gnt;
        if (w_acc_we) begin
          r_wr_addr <= w_acc_addr;
          r_wr_data <= w_acc_wdata;
        end else begin
          r_rd_addr <= w_acc_addr;
        end
      end
    end
  end

  // Outstanding-write counter; an ack with nothing outstanding is ignored.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_cnt <= '0;
    end else begin
      case ({w_wr_inc, w_wr_dec})
        2'b10:   r_wr_cnt <= r_wr_cnt + CNT_W'(1);
        2'b01:   r_wr_cnt <= r_wr_cnt - CNT_W'(1);
        default: r_wr_cnt <= r_wr_cnt;
      endcase
    end
  end

  // Route read returns to the owning requester; flag returns that match no entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rvalid <= '0;
      r_rdata0 <= '0;
      r_rdata1 <= '0;
      r_err    <= 1'b0;
    end else begin
      r_rvalid <= '0;
      if (bus.mc_rd_ret_ack && w_ret_hit) begin
        if (w_ret_id == 1'b0) begin
          r_rvalid[0] <= 1'b1;
          r_rdata0    <= bus.mc_rd_ret_data;
        end else begin
          r_rvalid[1] <= 1'b1;
          r_rdata1    <= bus.mc_rd_ret_data;
        end
      end else if (bus.mc_rd_ret_ack) begin
        r_err <= 1'b1;
      end
    end
  end

  assign bus.mc_wr_en      = r_wr_en;
  assign bus.mc_wr_address = r_wr_addr;
  assign bus.mc_wr_data    = r_wr_data;
  assign bus.mc_rd_en      = r_rd_en;
  assign bus.mc_rd_address = r_rd_addr;
  assign bus.req0_rvalid   = r_rvalid[0];
  assign bus.req0_rdata    = r_rdata0;
  assign bus.req1_rvalid   = r_rvalid[1];
  assign bus.req1_rdata    = r_rdata1;
  assign bus.err_unmatched = r_err;

endmodule
